// File: rtl/memory_mp_if.sv
// Client bus for memory_mp; per-port fields are flattened with port p in slice p.
interface memory_mp_if #(
  parameter int NPORTS = 2
);
  logic [NPORTS-1:0]    req;
  logic [NPORTS*32-1:0] addr;
  logic [NPORTS-1:0]    write;
  logic [NPORTS*32-1:0] wdata;
  logic [NPORTS-1:0]    extend;
  logic [NPORTS*2-1:0]  width;
  logic [NPORTS-1:0]    ack;
  logic [NPORTS-1:0]    rvalid;
  logic [NPORTS*32-1:0] rdata;
  logic [NPORTS-1:0]    err;

  modport master (
    output req, addr, write, wdata, extend, width,
    input  ack, rvalid, rdata, err
  );

  modport slave (
    input  req, addr, write, wdata, extend, width,
    output ack, rvalid, rdata, err
  );
endinterface

// File: rtl/memory_mp.sv
// Multi-port arbiter in front of a single byte-enabled 32-bit SRAM with sized/extended loads.
// Define MEMORY_MP_RR_EN for round-robin arbitration; default build is fixed priority (port 0 highest).
module memory_mp #(
  parameter int NPORTS = 2,
  parameter int DEPTH  = 16384,
  parameter int AW     = $clog2(DEPTH)
) (
  input logic        clk,
  input logic        reset_n,
  memory_mp_if.slave bus
);
  localparam int PW = (NPORTS > 1) ? $clog2(NPORTS) : 1;

  logic [NPORTS-1:0] gnt;
  logic [PW-1:0]     gnt_idx;
  logic              gnt_any;

`ifdef MEMORY_MP_RR_EN
  logic [PW-1:0] ptr;
  int            cand;

  // Search begins one past the last granted port so every requester gets a turn.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    cand    = 0;
    for (int k = 1; k <= NPORTS; k++) begin
      cand = (int'(ptr) + k) % NPORTS;
      if (!gnt_any && bus.req[cand]) begin
        gnt_any = 1'b1;
        gnt_idx = PW'(cand);
      end
    end
    if (!reset_n) gnt_any = 1'b0;
    if (gnt_any) gnt[gnt_idx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) ptr <= '0;
    else if (gnt_any) ptr <= gnt_idx;
  end
`else
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    for (int k = 0; k < NPORTS; k++) begin
      if (!gnt_any && bus.req[k]) begin
        gnt_any = 1'b1;
        gnt_idx = PW'(k);
      end
    end
    if (!reset_n) gnt_any = 1'b0;
    if (gnt_any) gnt[gnt_idx] = 1'b1;
  end
`endif

  logic [31:0]   g_addr;
  logic [31:0]   g_wdata;
  logic          g_write;
  logic          g_extend;
  logic [1:0]    g_width;
  logic          mis;
  logic [3:0]    be;
  logic [31:0]   wrep;
  logic [AW-1:0] word_addr;
  logic          do_store;
  logic          do_load;
  logic          unused_addr_bits;

  always_comb begin
    g_addr   = bus.addr[gnt_idx*32 +: 32];
    g_wdata  = bus.wdata[gnt_idx*32 +: 32];
    g_write  = bus.write[gnt_idx];
    g_extend = bus.extend[gnt_idx];
    g_width  = bus.width[gnt_idx*2 +: 2];
    mis      = (g_width == 2'b01 && g_addr[0]) || (g_width[1] && g_addr[1:0] != 2'b00);
    if (g_width[1]) begin
      be   = 4'b1111;
      wrep = g_wdata;
    end else if (g_width[0]) begin
      be   = g_addr[1] ? 4'b1100 : 4'b0011;
      wrep = {2{g_wdata[15:0]}};
    end else begin
      be   = 4'b0001 << g_addr[1:0];
      wrep = {4{g_wdata[7:0]}};
    end
    word_addr = g_addr[AW+1:2];
    do_store  = gnt_any && g_write && !mis;
    do_load   = gnt_any && !g_write && !mis;
  end

  // Upper address bits are deliberately dropped so accesses wrap modulo the array size.
  assign unused_addr_bits = ^g_addr[31:AW+2];

  logic [31:0] mem [DEPTH];
  logic [31:0] rd_word;
  logic [1:0]  off_q;
  logic [1:0]  width_q;
  logic        ext_q;

  always_ff @(posedge clk) begin
    if (do_store) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[word_addr][i*8 +: 8] <= wrep[i*8 +: 8];
      end
    end
    if (do_load) begin
      rd_word <= mem[word_addr];
      off_q   <= g_addr[1:0];
      width_q <= g_width;
      ext_q   <= g_extend;
    end
  end

  logic [7:0]  lane_b;
  logic [15:0] lane_h;
  logic [31:0] ld_data;

  always_comb begin
    lane_b = rd_word[off_q*8 +: 8];
    lane_h = off_q[1] ? rd_word[31:16] : rd_word[15:0];
    if (width_q[1]) ld_data = rd_word;
    else if (width_q[0]) ld_data = {{16{ext_q & lane_h[15]}}, lane_h};
    else ld_data = {{24{ext_q & lane_b[7]}}, lane_b};
  end

  logic [NPORTS-1:0]    rvalid_q;
  logic [NPORTS-1:0]    err_q;
  logic [NPORTS*32-1:0] hold;
  logic [NPORTS-1:0]    rv_out;

  // Only one port can be granted per cycle, so a single load return path is shared.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rvalid_q <= '0;
      err_q    <= '0;
      hold     <= '0;
    end else begin
      rvalid_q <= '0;
      err_q    <= '0;
      if (gnt_any && mis) err_q[gnt_idx] <= 1'b1;
      if (do_load) rvalid_q[gnt_idx] <= 1'b1;
      for (int p = 0; p < NPORTS; p++) begin
        if (rvalid_q[p]) hold[p*32 +: 32] <= ld_data;
      end
    end
  end

  // Gating with reset_n drops a load whose return cycle coincides with reset.
  assign rv_out     = rvalid_q & {NPORTS{reset_n}};
  assign bus.ack    = gnt;
  assign bus.rvalid = rv_out;
  assign bus.err    = err_q & {NPORTS{reset_n}};

  always_comb begin
    bus.rdata = hold;
    for (int p = 0; p < NPORTS; p++) begin
      if (rv_out[p]) bus.rdata[p*32 +: 32] = ld_data;
    end
  end
endmodule

// File: tb/tb_memory_mp.sv
// Scoreboard bench for memory_mp with three ports; build with MEMORY_MP_RR_EN to check round-robin grants.
module tb_memory_mp;
  localparam int NP   = 3;
  localparam int K_ST = 0;
  localparam int K_LD = 1;
  localparam int K_ER = 2;

  typedef struct {
    int          port;
    int          kind;
    logic [31:0] data;
    int          due;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n;

  always #5 clk = ~clk;

  memory_mp_if #(.NPORTS(NP)) bus ();

  memory_mp #(.NPORTS(NP)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  exp_t        sb[$];
  exp_t        cur;
  exp_t        item;
  int          total   = 0;
  int          bad     = 0;
  int          cyc     = 0;
  bit          mon_en  = 1'b0;
  logic [31:0] exp_hold [NP];
  int          exp_p;

  always @(posedge clk) cyc++;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("[TB] FAIL %s: got=%h want=%h (cycle %0d)", name, act, want, cyc);
    end
  endtask

  // One request on one port for exactly one cycle; expected response queued for the monitor.
  task automatic apply_stimulus(input int p, input logic [31:0] a, input logic wr, input logic [31:0] wd,
                                input logic [1:0] w, input logic ex, input int kind, input logic [31:0] expv);
    bus.req                = '0;
    bus.addr[p*32 +: 32]   = a;
    bus.write[p]           = wr;
    bus.wdata[p*32 +: 32]  = wd;
    bus.width[p*2 +: 2]    = w;
    bus.extend[p]          = ex;
    bus.req[p]             = 1'b1;
    #1;
    check_output("ack", 32'(bus.ack), 32'(1) << p);
    if (kind == K_LD) exp_hold[p] = expv;
    if (kind != K_ST) begin
      item.port = p;
      item.kind = kind;
      item.data = exp_hold[p];
      item.due  = cyc + 1;
      sb.push_back(item);
    end
    @(posedge clk);
    #1;
    bus.req = '0;
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      while (sb.size() > 0 && sb[0].due < cyc) begin
        total++;
        bad++;
        $display("[TB] FAIL missing_resp: port %0d due cycle %0d, no response by cycle %0d", sb[0].port, sb[0].due, cyc);
        void'(sb.pop_front());
      end
      if ((bus.rvalid | bus.err) != '0) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("[TB] FAIL unexpected_resp: rvalid=%b err=%b want none", bus.rvalid, bus.err);
        end else begin
          cur = sb.pop_front();
          check_output("resp_cycle", 32'(cyc), 32'(cur.due));
          check_output("resp_rvalid", 32'(bus.rvalid), (cur.kind == K_LD) ? (32'(1) << cur.port) : 32'(0));
          check_output("resp_err", 32'(bus.err), (cur.kind == K_ER) ? (32'(1) << cur.port) : 32'(0));
          check_output("resp_rdata", bus.rdata[cur.port*32 +: 32], cur.data);
        end
      end
    end
  end

  initial begin
    bus.req    = '1;
    bus.addr   = '0;
    bus.write  = '0;
    bus.wdata  = '0;
    bus.extend = '0;
    bus.width  = '1;
    reset_n    = 1'b0;
    for (int p = 0; p < NP; p++) exp_hold[p] = '0;

    repeat (2) @(posedge clk);
    #1;
    check_output("reset_ack", 32'(bus.ack), 32'(0));
    check_output("reset_rvalid", 32'(bus.rvalid), 32'(0));
    check_output("reset_err", 32'(bus.err), 32'(0));
    for (int p = 0; p < NP; p++) check_output("reset_rdata", bus.rdata[p*32 +: 32], 32'h0);
    bus.req = '0;
    reset_n = 1'b1;
    mon_en  = 1'b1;
    @(posedge clk);
    #1;

    apply_stimulus(1, 32'h10,    1'b1, 32'hDEADBEEF, 2'b10, 1'b0, K_ST, 32'h0);
    apply_stimulus(0, 32'h13,    1'b0, 32'h0,        2'b00, 1'b1, K_LD, 32'hFFFFFFDE);
    apply_stimulus(0, 32'h12,    1'b0, 32'h0,        2'b01, 1'b0, K_LD, 32'h0000DEAD);
    apply_stimulus(2, 32'h10010, 1'b0, 32'h0,        2'b10, 1'b0, K_LD, 32'hDEADBEEF);
    apply_stimulus(1, 32'h11,    1'b0, 32'h0,        2'b00, 1'b1, K_LD, 32'hFFFFFFBE);

    apply_stimulus(0, 32'h20, 1'b1, 32'h11223344, 2'b10, 1'b0, K_ST, 32'h0);
    apply_stimulus(0, 32'h21, 1'b1, 32'h0000005A, 2'b00, 1'b0, K_ST, 32'h0);
    apply_stimulus(1, 32'h20, 1'b0, 32'h0,        2'b10, 1'b0, K_LD, 32'h11225A44);
    apply_stimulus(2, 32'h20, 1'b0, 32'h0,        2'b00, 1'b1, K_LD, 32'h00000044);

    apply_stimulus(1, 32'h22, 1'b0, 32'h0,        2'b10, 1'b0, K_ER, 32'h0);
    apply_stimulus(2, 32'h21, 1'b1, 32'h0000BEEF, 2'b01, 1'b0, K_ER, 32'h0);
    apply_stimulus(0, 32'h20, 1'b0, 32'h0,        2'b10, 1'b0, K_LD, 32'h11225A44);
    apply_stimulus(0, 32'h23, 1'b0, 32'h0,        2'b01, 1'b1, K_ER, 32'h0);

    apply_stimulus(1, 32'h22, 1'b1, 32'h0000CAFE, 2'b01, 1'b0, K_ST, 32'h0);
    apply_stimulus(2, 32'h22, 1'b0, 32'h0,        2'b01, 1'b1, K_LD, 32'hFFFFCAFE);
    apply_stimulus(0, 32'h20, 1'b0, 32'h0,        2'b10, 1'b0, K_LD, 32'hCAFE5A44);

    // A load followed immediately by a store to the same word must see the old contents.
    apply_stimulus(0, 32'h30, 1'b1, 32'h01020304, 2'b10, 1'b0, K_ST, 32'h0);
    apply_stimulus(1, 32'h30, 1'b0, 32'h0,        2'b10, 1'b0, K_LD, 32'h01020304);
    apply_stimulus(0, 32'h30, 1'b1, 32'hAAAAAAAA, 2'b10, 1'b0, K_ST, 32'h0);
    apply_stimulus(2, 32'h30, 1'b0, 32'h0,        2'b10, 1'b0, K_LD, 32'hAAAAAAAA);
    apply_stimulus(0, 32'h33, 1'b1, 32'h00000077, 2'b00, 1'b0, K_ST, 32'h0);
    apply_stimulus(2, 32'h30, 1'b0, 32'h0,        2'b10, 1'b0, K_LD, 32'h77AAAAAA);
    apply_stimulus(1, 32'h32, 1'b0, 32'h0,        2'b01, 1'b0, K_LD, 32'h000077AA);

    @(posedge clk);
    #1;
    mon_en = 1'b0;

    bus.addr[0 +: 32] = 32'h10;
    bus.write[0]      = 1'b0;
    bus.width[0 +: 2] = 2'b10;
    bus.extend[0]     = 1'b0;
    bus.req           = 3'b001;
    #1;
    check_output("ack_before_reset", 32'(bus.ack), 32'h1);
    @(posedge clk);
    #1;
    bus.req = '0;
    reset_n = 1'b0;
    #1;
    check_output("rvalid_dropped", 32'(bus.rvalid), 32'(0));
    check_output("rdata0_held_in_reset", bus.rdata[0 +: 32], exp_hold[0]);
    @(posedge clk);
    #1;
    check_output("rvalid_after_reset", 32'(bus.rvalid), 32'(0));
    for (int p = 0; p < NP; p++) begin
      check_output("rdata_after_reset", bus.rdata[p*32 +: 32], 32'h0);
      exp_hold[p] = '0;
    end

    for (int p = 0; p < NP; p++) begin
      bus.addr[p*32 +: 32] = 32'h10;
      bus.write[p]         = 1'b0;
      bus.width[p*2 +: 2]  = 2'b10;
      bus.extend[p]        = 1'b0;
    end
    bus.req = '1;
    #1;
    check_output("ack_in_reset", 32'(bus.ack), 32'(0));
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    mon_en  = 1'b1;
    for (int i = 0; i < 6; i++) begin
      #1;
`ifdef MEMORY_MP_RR_EN
      exp_p = (i + 1) % NP;
`else
      exp_p = 0;
`endif
      check_output("contention_ack", 32'(bus.ack), 32'(1) << exp_p);
      exp_hold[exp_p] = 32'hDEADBEEF;
      item.port = exp_p;
      item.kind = K_LD;
      item.data = 32'hDEADBEEF;
      item.due  = cyc + 1;
      sb.push_back(item);
      @(posedge clk);
      #1;
    end
    bus.req = '0;

    repeat (3) @(posedge clk);
    #1;
    check_output("scoreboard_drained", 32'(sb.size()), 32'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
